// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//
// Sequential write-side loader for single-port synchronous memories. A
// valid/ready word stream is written to consecutive addresses starting at a
// programmed start address. Addresses wrap from MEM_SIZE-1 to 0, and MEM_SIZE
// need not be a power of two.
//
// Parameters
//   MEM_SIZE    words in the target memory (MEM_SIZE <= 2**ADDR_WIDTH)
//   ADDR_WIDTH  memory address width
//   DATA_WIDTH  memory word width
//
// Ports
//   clk         in   clock, all logic on posedge
//   rst_b       in   asynchronous active-low reset
//   start       in   one-cycle pulse, begins a load (honoured only in IDLE)
//   abort       in   terminate the load, return to IDLE without a done pulse
//   start_addr  in   [ADDR_WIDTH-1:0]  first write address, sampled on start
//   word_count  in   [ADDR_WIDTH:0]    words to load, sampled on start
//                                      (values above MEM_SIZE are clamped)
//   s_valid     in   input word valid
//   s_data      in   [DATA_WIDTH-1:0]  input word
//   s_ready     out  loader accepts a word this cycle
//   mem_we      out  memory write enable (registered)
//   mem_addr    out  [ADDR_WIDTH-1:0]  memory write address (registered)
//   mem_wdata   out  [DATA_WIDTH-1:0]  memory write data (registered)
//   busy        out  high while in LOAD or FINISH
//   done        out  one-cycle pulse, coincides with the last write
//   wrapped     out  sticky: the address wrapped to 0 during the current load
//   checksum    out  [DATA_WIDTH-1:0]  (only with MEM_LOADER_CHKSUM_EN)
//                    modular sum of all accepted words of the current load
//
// Build option
//   MEM_LOADER_CHKSUM_EN  when defined, adds the checksum output and adder.
// -----------------------------------------------------------------------------
module mem_loader #(
  parameter int MEM_SIZE   = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped
`ifdef MEM_LOADER_CHKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH:0]   MEM_SIZE_C = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Load bookkeeping
  logic [ADDR_WIDTH-1:0] addr_q;        // address the next accepted word goes to
  logic [ADDR_WIDTH:0]   rem_q;         // words still to be accepted
  logic                  wrap_armed_q;  // address has rolled over to 0
  logic                  wrapped_q;

  // Registered memory write port
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  hs;
  logic                  accept_start;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Requests larger than the memory would overwrite words of this same load.
  function automatic logic [ADDR_WIDTH:0] clamp_count(input logic [ADDR_WIDTH:0] cnt);
    return (cnt > MEM_SIZE_C) ? MEM_SIZE_C : cnt;
  endfunction

  // Wrap at MEM_SIZE-1 rather than relying on power-of-two overflow. The >=
  // also folds an out-of-range start address back into the memory.
  function automatic logic [ADDR_WIDTH-1:0] incr_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a >= LAST_ADDR) ? '0 : a + ADDR_ONE;
  endfunction

  assign hs           = s_valid & s_ready;
  assign accept_start = (state_q == IDLE) & start & ~abort;
  assign last_word    = hs & (rem_q == CNT_ONE);
  assign addr_next    = incr_addr(addr_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (abort overrides everything)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = (word_count == '0) ? FINISH : LOAD;
          end
        end
        LOAD: begin
          if (last_word) begin
            state_d = FINISH;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_ready = 1'b0;
        busy    = 1'b0;
      end
      LOAD: begin
        // Dropping ready on abort keeps the aborted cycle from accepting a word.
        s_ready = ~abort;
        busy    = 1'b1;
      end
      FINISH: begin
        // FINISH is entered the cycle the last write appears, so done lines up
        // with that write. An abort arriving here suppresses the pulse.
        done = ~abort;
        busy = 1'b1;
      end
      default: begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load bookkeeping: address, remaining count, wrap tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      addr_q       <= '0;
      rem_q        <= '0;
      wrap_armed_q <= 1'b0;
      wrapped_q    <= 1'b0;
    end else if (accept_start) begin
      addr_q       <= start_addr;
      rem_q        <= clamp_count(word_count);
      wrap_armed_q <= 1'b0;
      wrapped_q    <= 1'b0;
    end else if (hs) begin
      addr_q <= addr_next;
      rem_q  <= rem_q - CNT_ONE;
      if (addr_q >= LAST_ADDR) begin
        wrap_armed_q <= 1'b1;
      end
      // A handshake after the rollover is the word headed for address 0, so
      // wrapped rises in the same cycle that write appears on the port.
      if (wrap_armed_q) begin
        wrapped_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory write port: one cycle behind the handshake, holds when idle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= hs;
      if (hs) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= s_data;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wrapped   = wrapped_q;

`ifdef MEM_LOADER_CHKSUM_EN
  // ---------------------------------------------------------------------------
  // Running checksum of accepted words; final value appears with done
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] chk_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      chk_q <= '0;
    end else if (accept_start) begin
      chk_q <= '0;
    end else if (hs) begin
      chk_q <= chk_q + s_data;
    end
  end

  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  localparam int MS = 1000;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start;
  logic          abort;
  logic [AW-1:0] start_addr;
  logic [AW:0]   word_count;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          wrapped;
`ifdef MEM_LOADER_CHKSUM_EN
  logic [DW-1:0] checksum;
`endif

  mem_loader #(
    .MEM_SIZE  (MS),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .abort     (abort),
    .start_addr(start_addr),
    .word_count(word_count),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .wrapped   (wrapped)
`ifdef MEM_LOADER_CHKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // One record = inputs driven during a cycle and outputs expected in that cycle.
  typedef struct {
    logic          st;
    logic          ab;
    logic [AW-1:0] sa;
    logic [AW:0]   wc;
    logic          sv;
    logic [DW-1:0] sd;
    logic          rdy;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          bsy;
    logic          dn;
    logic          wrp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t v(input int st, input int ab, input int sa, input int wc,
                             input int sv, input logic [DW-1:0] sd,
                             input int rdy, input int we, input int addr,
                             input logic [DW-1:0] wd, input int bsy, input int dn,
                             input int wrp);
    vec_t r;
    r.st   = 1'(st);
    r.ab   = 1'(ab);
    r.sa   = AW'(sa);
    r.wc   = (AW+1)'(wc);
    r.sv   = 1'(sv);
    r.sd   = sd;
    r.rdy  = 1'(rdy);
    r.we   = 1'(we);
    r.addr = AW'(addr);
    r.wd   = wd;
    r.bsy  = 1'(bsy);
    r.dn   = 1'(dn);
    r.wrp  = 1'(wrp);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start      = 1'b0;
    abort      = 1'b0;
    start_addr = '0;
    word_count = '0;
    s_valid    = 1'b0;
    s_data     = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int            k;
    int            nw;
    bit            seen;

    // inputs: st ab sa wc sv sd | expected: rdy we addr wdata busy done wrapped
    // 4 words with s_valid held high from 0x010
    vecs.push_back(v(0,0,'h000,0,0,32'h0,        0,0,'h000,32'h0,  0,0,0));
    vecs.push_back(v(1,0,'h010,4,1,32'hA0,       0,0,'h000,32'h0,  0,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hA0,           1,0,'h000,32'h0,  1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hA1,           1,1,'h010,32'hA0, 1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hA2,           1,1,'h011,32'hA1, 1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hA3,           1,1,'h012,32'hA2, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,1,'h013,32'hA3, 1,1,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,0,'h013,32'hA3, 0,0,0));
    // 3 words with s_valid toggling; gap data must not be written
    vecs.push_back(v(1,0,'h000,3,0,32'h0,        0,0,'h013,32'hA3, 0,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hB0,           1,0,'h013,32'hA3, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,32'hFFFFFFFF,     1,1,'h000,32'hB0, 1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hB1,           1,0,'h000,32'hB0, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,32'hFFFFFFFF,     1,1,'h001,32'hB1, 1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hB2,           1,0,'h001,32'hB1, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,1,'h002,32'hB2, 1,1,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,0,'h002,32'hB2, 0,0,0));
    // wrap at MEM_SIZE-1 = 999: addresses 998, 999, 0, 1
    vecs.push_back(v(1,0,998,4,0,32'h0,          0,0,'h002,32'hB2, 0,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hC0,           1,0,'h002,32'hB2, 1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hC1,           1,1,998,32'hC0,   1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hC2,           1,1,999,32'hC1,   1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hC3,           1,1,0,32'hC2,     1,0,1));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,1,1,32'hC3,     1,1,1));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,0,1,32'hC3,     0,0,1));
    // zero-length load: done the cycle after start, busy one cycle, wrapped cleared
    vecs.push_back(v(1,0,'h055,0,0,32'h0,        0,0,1,32'hC3,     0,0,1));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,0,1,32'hC3,     1,1,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,0,1,32'hC3,     0,0,0));
    // abort after 2 of 8 words (wrapping); restart the next cycle clears wrapped
    vecs.push_back(v(1,0,999,8,0,32'h0,          0,0,1,32'hC3,     0,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hD0,           1,0,1,32'hC3,     1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hD1,           1,1,999,32'hD0,   1,0,0));
    vecs.push_back(v(0,1,0,0,1,32'hD2,           0,1,0,32'hD1,     1,0,1));
    vecs.push_back(v(1,0,'h020,2,0,32'h0,        0,0,0,32'hD1,     0,0,1));
    vecs.push_back(v(0,0,0,0,1,32'hE0,           1,0,0,32'hD1,     1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hE1,           1,1,'h020,32'hE0, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,1,'h021,32'hE1, 1,1,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,0,'h021,32'hE1, 0,0,0));
    // start during LOAD is ignored
    vecs.push_back(v(1,0,'h100,2,0,32'h0,        0,0,'h021,32'hE1, 0,0,0));
    vecs.push_back(v(1,0,'h300,5,0,32'h0,        1,0,'h021,32'hE1, 1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hF0,           1,0,'h021,32'hE1, 1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'hF1,           1,1,'h100,32'hF0, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,1,'h101,32'hF1, 1,1,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,0,'h101,32'hF1, 0,0,0));
    // abort beats start in IDLE
    vecs.push_back(v(1,1,'h010,3,0,32'h0,        0,0,'h101,32'hF1, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,0,'h101,32'hF1, 0,0,0));
    // abort in FINISH suppresses done
    vecs.push_back(v(1,0,'h000,0,0,32'h0,        0,0,'h101,32'hF1, 0,0,0));
    vecs.push_back(v(0,1,0,0,0,32'h0,            0,0,'h101,32'hF1, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,32'h0,            0,0,'h101,32'hF1, 0,0,0));

    // Reset
    idle_inputs();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.s_ready",   64'(s_ready),   64'd0);
    chk("rst.mem_we",    64'(mem_we),    64'd0);
    chk("rst.mem_addr",  64'(mem_addr),  64'd0);
    chk("rst.mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst.busy",      64'(busy),      64'd0);
    chk("rst.done",      64'(done),      64'd0);
    chk("rst.wrapped",   64'(wrapped),   64'd0);
`ifdef MEM_LOADER_CHKSUM_EN
    chk("rst.checksum",  64'(checksum),  64'd0);
`endif
    rst_b = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start      = vecs[i].st;
      abort      = vecs[i].ab;
      start_addr = vecs[i].sa;
      word_count = vecs[i].wc;
      s_valid    = vecs[i].sv;
      s_data     = vecs[i].sd;
      #1;
      chk($sformatf("v%0d.s_ready", i),   64'(s_ready),   64'(vecs[i].rdy));
      chk($sformatf("v%0d.mem_we", i),    64'(mem_we),    64'(vecs[i].we));
      chk($sformatf("v%0d.mem_addr", i),  64'(mem_addr),  64'(vecs[i].addr));
      chk($sformatf("v%0d.mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].wd));
      chk($sformatf("v%0d.busy", i),      64'(busy),      64'(vecs[i].bsy));
      chk($sformatf("v%0d.done", i),      64'(done),      64'(vecs[i].dn));
      chk($sformatf("v%0d.wrapped", i),   64'(wrapped),   64'(vecs[i].wrp));
    end

    // word_count above MEM_SIZE clamps to 1000 words from address 0
    @(negedge clk);
    idle_inputs();
    start      = 1'b1;
    word_count = (AW+1)'(1500);
    s_valid    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k     = 0;
    nw    = 0;
    seen  = 1'b0;
    for (int c = 0; c < 1100 && !seen; c++) begin
      s_data = DW'(k);
      #1;
      if (s_ready) k++;
      if (mem_we) nw++;
      if (done) begin
        seen = 1'b1;
        chk("clamp.last_addr",  64'(mem_addr),  64'd999);
        chk("clamp.last_wdata", 64'(mem_wdata), 64'd999);
        chk("clamp.wrapped",    64'(wrapped),   64'd0);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("clamp.done_seen", 64'(seen), 64'd1);
    chk("clamp.writes",    64'(nw),   64'd1000);
    #1;
    chk("clamp.busy_after", 64'(busy), 64'd0);

    // Reset in the middle of a wrapping load clears everything at once
    @(negedge clk);
    start      = 1'b1;
    start_addr = AW'(999);
    word_count = (AW+1)'(6);
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h1111_0000;
    @(negedge clk);
    s_data  = 32'h1111_0001;
    @(negedge clk);
    s_data  = 32'h1111_0002;
    #1;
    chk("midrst.pre_wrapped", 64'(wrapped),   64'd1);
    chk("midrst.pre_wdata",   64'(mem_wdata), 64'h1111_0001);
    #1;
    rst_b = 1'b0;
    #1;
    chk("midrst.s_ready",   64'(s_ready),   64'd0);
    chk("midrst.mem_we",    64'(mem_we),    64'd0);
    chk("midrst.mem_addr",  64'(mem_addr),  64'd0);
    chk("midrst.mem_wdata", 64'(mem_wdata), 64'd0);
    chk("midrst.busy",      64'(busy),      64'd0);
    chk("midrst.wrapped",   64'(wrapped),   64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst.no_resume_busy",  64'(busy),    64'd0);
    chk("midrst.no_resume_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;

`ifdef MEM_LOADER_CHKSUM_EN
    // Modular checksum: 0xFFFFFFFF + 2 = 1
    @(negedge clk);
    idle_inputs();
    start      = 1'b1;
    word_count = (AW+1)'(2);
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    s_data  = 32'h0000_0002;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("chk.done",     64'(done),     64'd1);
    chk("chk.checksum", 64'(checksum), 64'd1);
    @(negedge clk);
    #1;
    chk("chk.held", 64'(checksum), 64'd1);
    @(negedge clk);
    start      = 1'b1;
    word_count = (AW+1)'(1);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("chk.cleared", 64'(checksum), 64'd0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
